// File: rtl/button_pulse_ctrl.sv
// Push-button conditioner: per channel 2-FF sync, debounce, press/release pulses, optional auto-repeat.
// Latency: raw change to btn_level/btn_pulse is DEBOUNCE_CYCLES+2 cycles; no backpressure (free-running outputs).
module button_pulse_ctrl #(
    parameter int N_CH            = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 20
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse,
    output logic [N_CH-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             stable;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] rcnt;
        logic [CNT_W-1:0] rcnt_nxt;
        state_t           state;
        state_t           state_nxt;
        logic             pulse_nxt;
        logic             rel_nxt;
        logic             level_q;
        logic             pulse_q;
        logic             rel_q;

        // Any cycle where s2 agrees with the stable value restarts the count.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                stable <= 1'b0;
                cnt    <= CNT_ZERO;
            end else begin
                s1 <= btn_raw[g];
                s2 <= s1;
                if (s2 == stable) begin
                    cnt <= CNT_ZERO;
                end else if (cnt == DEB_LAST) begin
                    stable <= s2;
                    cnt    <= CNT_ZERO;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt;
            pulse_nxt = 1'b0;
            rel_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    if (stable) begin
                        state_nxt = HOLD;
                        rcnt_nxt  = CNT_ZERO;
                        pulse_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stable) begin
                        state_nxt = IDLE;
                        rcnt_nxt  = CNT_ZERO;
                        rel_nxt   = 1'b1;
                    end else if (!repeat_en[g]) begin
                        rcnt_nxt = CNT_ZERO;
                    end else if (rcnt == DLY_LAST) begin
                        state_nxt = REPEAT;
                        rcnt_nxt  = CNT_ZERO;
                        pulse_nxt = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    // A release in the cycle a repeat would fire suppresses that repeat.
                    if (!stable) begin
                        state_nxt = IDLE;
                        rcnt_nxt  = CNT_ZERO;
                        rel_nxt   = 1'b1;
                    end else if (!repeat_en[g]) begin
                        state_nxt = HOLD;
                        rcnt_nxt  = CNT_ZERO;
                    end else if (rcnt == PER_LAST) begin
                        rcnt_nxt  = CNT_ZERO;
                        pulse_nxt = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = CNT_ZERO;
                end
            endcase
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                state   <= IDLE;
                rcnt    <= CNT_ZERO;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                rcnt    <= rcnt_nxt;
                level_q <= stable;
                pulse_q <= pulse_nxt;
                rel_q   <= rel_nxt;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_pulse[g]   = pulse_q;
        assign btn_release[g] = rel_q;
    end

endmodule

// File: tb/tb_button_pulse_ctrl.sv
// Bench for button_pulse_ctrl: tasks drive buttons and queue expected pulse/release events keyed by cycle;
// a negedge monitor pops every observed event from the scoreboard.
module tb_button_pulse_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] btn_raw;
    logic [2:0] repeat_en;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;
    logic [2:0] btn_release;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int exp_q[$];

    button_pulse_ctrl #(
        .N_CH(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .CNT_W(20)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .btn_raw(btn_raw),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release)
    );

    always #5 Clk = ~Clk;

    // cyc holds the index of the most recent rising edge.
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        int   key;
        int   idx;
        logic hit;
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 2; k++) begin
                hit = (k == 0) ? btn_pulse[ch] : btn_release[ch];
                if (hit === 1'b1) begin
                    key = cyc * 8 + ch * 2 + k;
                    idx = -1;
                    foreach (exp_q[i]) if (exp_q[i] == key) idx = i;
                    checks++;
                    if (idx < 0)
                        $display("FAIL sb_event ch%0d %s at cycle %0d: actual=1 required=0 (unexpected)",
                                 ch, (k == 0) ? "btn_pulse" : "btn_release", cyc);
                    else begin
                        exp_q.delete(idx);
                        passes++;
                    end
                end
            end
        end
    end

    task automatic push(input int c, input int ch, input int k);
        exp_q.push_back(c * 8 + ch * 2 + k);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic test_reset();
        int e0;
        int e1;
        Reset = 1'b1; btn_raw = 3'b111; repeat_en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if ({btn_level, btn_pulse, btn_release} !== 9'b0)
                $display("FAIL reset_outputs cycle %0d: actual=%b required=0", cyc, {btn_level, btn_pulse, btn_release});
            else passes++;
        end
        Reset = 1'b0;
        e0 = cyc + 1;
        for (int ch = 0; ch < 3; ch++) push(e0 + 6, ch, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            checks++;
            if (btn_level !== 3'b000)
                $display("FAIL post_reset_level cycle %0d: actual=%b required=000", cyc, btn_level);
            else passes++;
        end
        wait_to(e0 + 6);
        checks++;
        if (btn_level !== 3'b111) $display("FAIL reset_release_level: actual=%b required=111", btn_level);
        else passes++;
        btn_raw = 3'b000;
        e1 = cyc + 1;
        for (int ch = 0; ch < 3; ch++) push(e1 + 6, ch, 1);
        wait_to(e1 + 10);
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_press();
        int e0;
        int e1;
        btn_raw = 3'b010;
        e0 = cyc + 1;
        push(e0 + 6, 1, 0);
        wait_to(e0 + 5);
        checks++;
        if (btn_level !== 3'b000) $display("FAIL press_level_early: actual=%b required=000", btn_level);
        else passes++;
        wait_to(e0 + 6);
        checks++;
        if (btn_level !== 3'b010) $display("FAIL press_level_edge6: actual=%b required=010", btn_level);
        else passes++;
        wait_to(e0 + 35);
        btn_raw = 3'b000;
        e1 = cyc + 1;
        push(e1 + 6, 1, 1);
        wait_to(e1 + 5);
        checks++;
        if (btn_level !== 3'b010) $display("FAIL press_level_held: actual=%b required=010", btn_level);
        else passes++;
        wait_to(e1 + 6);
        checks++;
        if (btn_level !== 3'b000) $display("FAIL press_level_released: actual=%b required=000", btn_level);
        else passes++;
        wait_to(e1 + 10);
        checks++;
        if (exp_q.size() != 0) $display("FAIL press_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_glitch();
        int e0;
        int e1;
        btn_raw = 3'b010;
        e0 = cyc + 1;
        wait_to(e0 + 2);
        btn_raw = 3'b000;
        wait_to(e0 + 3);
        btn_raw = 3'b010;
        push(e0 + 10, 1, 0);
        wait_to(e0 + 7);
        checks++;
        if (btn_level !== 3'b000) $display("FAIL glitch_rejected: actual=%b required=000", btn_level);
        else passes++;
        wait_to(e0 + 9);
        checks++;
        if (btn_level !== 3'b000) $display("FAIL glitch_count_restart: actual=%b required=000", btn_level);
        else passes++;
        wait_to(e0 + 10);
        checks++;
        if (btn_level !== 3'b010) $display("FAIL glitch_then_press: actual=%b required=010", btn_level);
        else passes++;
        btn_raw = 3'b000;
        e1 = cyc + 1;
        push(e1 + 6, 1, 1);
        wait_to(e1 + 10);
        checks++;
        if (exp_q.size() != 0) $display("FAIL glitch_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_repeat();
        int e0;
        int offs[7] = '{6, 22, 30, 38, 46, 54, 62};
        repeat_en = 3'b010;
        btn_raw   = 3'b010;
        e0 = cyc + 1;
        foreach (offs[i]) push(e0 + offs[i], 1, 0);
        // Release lands on edge 70, exactly where the next repeat would fire.
        push(e0 + 70, 1, 1);
        wait_to(e0 + 63);
        btn_raw = 3'b000;
        wait_to(e0 + 69);
        checks++;
        if (btn_level !== 3'b010) $display("FAIL repeat_level_held: actual=%b required=010", btn_level);
        else passes++;
        wait_to(e0 + 70);
        checks++;
        if ({btn_pulse[1], btn_release[1]} !== 2'b01)
            $display("FAIL repeat_release_wins: actual=%b required=01", {btn_pulse[1], btn_release[1]});
        else passes++;
        wait_to(e0 + 74);
        checks++;
        if (exp_q.size() != 0) $display("FAIL repeat_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
        repeat_en = 3'b000;
    endtask

    task automatic test_repeat_en_toggle();
        int e0;
        repeat_en = 3'b010;
        btn_raw   = 3'b010;
        e0 = cyc + 1;
        push(e0 + 6, 1, 0);
        push(e0 + 22, 1, 0);
        push(e0 + 56, 1, 0);
        push(e0 + 64, 1, 0);
        push(e0 + 66, 1, 1);
        wait_to(e0 + 25);
        repeat_en = 3'b000;
        wait_to(e0 + 30);
        checks++;
        if (btn_pulse[1] !== 1'b0) $display("FAIL toggle_no_pulse_30: actual=%b required=0", btn_pulse[1]);
        else passes++;
        wait_to(e0 + 40);
        repeat_en = 3'b010;
        wait_to(e0 + 59);
        btn_raw = 3'b000;
        wait_to(e0 + 70);
        checks++;
        if (exp_q.size() != 0) $display("FAIL toggle_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
        repeat_en = 3'b000;
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        int e2;
        btn_raw = 3'b100;
        e0 = cyc + 1;
        push(e0 + 6, 2, 0);
        wait_to(e0 + 10);
        btn_raw = 3'b001;
        e1 = cyc + 1;
        push(e1 + 6, 0, 0);
        push(e1 + 6, 2, 1);
        wait_to(e1 + 6);
        checks++;
        if ({btn_pulse[0], btn_release[2]} !== 2'b11)
            $display("FAIL b2b_same_cycle: actual=%b required=11", {btn_pulse[0], btn_release[2]});
        else passes++;
        repeat_en = 3'b010;
        btn_raw   = 3'b011;
        e2 = cyc + 1;
        push(e2 + 6, 1, 0);
        push(e2 + 22, 1, 0);
        push(e2 + 30, 1, 0);
        wait_to(e2 + 33);
        Reset = 1'b1;
        wait_to(e2 + 34);
        checks++;
        if ({btn_level, btn_pulse, btn_release} !== 9'b0)
            $display("FAIL midrepeat_reset_outputs: actual=%b required=0", {btn_level, btn_pulse, btn_release});
        else passes++;
        Reset = 1'b0;
        push(e2 + 41, 0, 0);
        push(e2 + 41, 1, 0);
        wait_to(e2 + 40);
        checks++;
        if (btn_level !== 3'b000) $display("FAIL post_reset_redebounce: actual=%b required=000", btn_level);
        else passes++;
        wait_to(e2 + 41);
        checks++;
        if (btn_level !== 3'b011) $display("FAIL post_reset_level: actual=%b required=011", btn_level);
        else passes++;
        wait_to(e2 + 42);
        btn_raw = 3'b000;
        push(e2 + 49, 0, 1);
        push(e2 + 49, 1, 1);
        wait_to(e2 + 55);
        checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_missing: actual=%0d required=0 outstanding", exp_q.size());
        else passes++;
        exp_q.delete();
        repeat_en = 3'b000;
    endtask

    initial begin
        Reset = 1'b1; btn_raw = 3'b000; repeat_en = 3'b000;
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_repeat_en_toggle();
        test_back_to_back();
        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
